// File: rtl/dcache_if.sv
// dcache_if: MEM-stage request, data/tag RAM and L2 signals of the L1 dcache controller.
interface dcache_if;
  logic         dc_req;
  logic         dc_rw;
  logic [31:0]  dc_addr;
  logic [31:0]  dc_wr_data;
  logic         dc_done;
  logic [31:0]  dc_rd_data;
  logic         dc_stall;
  logic [7:0]   index;
  logic [1:0]   dc_offset;
  logic         block0_re;
  logic         block1_re;
  logic         block0_we;
  logic         block1_we;
  logic         l2_wr_dc_en;
  logic         data_wd_dc_en;
  logic [31:0]  dc_wd;
  logic [127:0] dc_data_wd;
  logic [127:0] data0_rd;
  logic [127:0] data1_rd;
  logic [21:0]  tag0_rd;
  logic [21:0]  tag1_rd;
  logic         tag0_we;
  logic         tag1_we;
  logic [21:0]  tag_wd;
  logic         l2_rd_req;
  logic         l2_wb_req;
  logic [31:0]  l2_addr;
  logic [127:0] l2_wb_data;
  logic         l2_ack;
  logic [127:0] l2_rd_data;
  modport slave (
    input  dc_req, dc_rw, dc_addr, dc_wr_data, data0_rd, data1_rd, tag0_rd, tag1_rd, l2_ack, l2_rd_data,
    output dc_done, dc_rd_data, dc_stall, index, dc_offset, block0_re, block1_re, block0_we, block1_we,
           l2_wr_dc_en, data_wd_dc_en, dc_wd, dc_data_wd, tag0_we, tag1_we, tag_wd,
           l2_rd_req, l2_wb_req, l2_addr, l2_wb_data
  );
  modport master (
    output dc_req, dc_rw, dc_addr, dc_wr_data, data0_rd, data1_rd, tag0_rd, tag1_rd, l2_ack, l2_rd_data,
    input  dc_done, dc_rd_data, dc_stall, index, dc_offset, block0_re, block1_re, block0_we, block1_we,
           l2_wr_dc_en, data_wd_dc_en, dc_wd, dc_data_wd, tag0_we, tag1_we, tag_wd,
           l2_rd_req, l2_wb_req, l2_addr, l2_wb_data
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: control FSM of a 2-way set-associative L1 dcache with LRU replacement and writeback.
module dcache_ctrl #(
  parameter int TAG_W = 20,
  parameter int IDX_W = 8
) (
  input logic      clk,
  input logic      rst,
  dcache_if.slave  io_dc
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_ALLOC  = 3'd3;
  localparam logic [2:0] S_REFILL = 3'd4;
  logic [2:0]              r_state;
  logic                    r_victim;
  logic [TAG_W-1:0]        r_vic_tag;
  logic [127:0]            r_vic_line;
  logic [127:0]            r_line;
  logic [(1<<IDX_W)-1:0]   r_lru;
  logic [TAG_W-1:0]        w_tag;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_idle, w_acc, w_wb, w_alloc, w_ref;
  logic                    w_hit0, w_hit1, w_hit, w_st_hit, w_vic;
  logic [TAG_W+1:0]        w_vtag;
  logic [127:0]            w_line;
  logic [2:0]              w_next;
  assign w_tag   = io_dc.dc_addr[31:32-TAG_W];
  assign w_idx   = io_dc.dc_addr[IDX_W+3:4];
  // State decodes are gated by rst so every strobe is quiet during the reset cycle.
  assign w_idle  = ~rst & (r_state == S_IDLE);
  assign w_acc   = ~rst & (r_state == S_ACCESS);
  assign w_wb    = ~rst & (r_state == S_WB);
  assign w_alloc = ~rst & (r_state == S_ALLOC);
  assign w_ref   = ~rst & (r_state == S_REFILL);
  assign w_hit0   = io_dc.tag0_rd[TAG_W+1] & (io_dc.tag0_rd[TAG_W-1:0] == w_tag);
  assign w_hit1   = ~w_hit0 & io_dc.tag1_rd[TAG_W+1] & (io_dc.tag1_rd[TAG_W-1:0] == w_tag);
  assign w_hit    = w_hit0 | w_hit1;
  assign w_st_hit = w_acc & w_hit & io_dc.dc_rw;
  assign w_line   = w_hit1 ? io_dc.data1_rd : io_dc.data0_rd;
  // Invalid ways are filled first; otherwise LRU=1 (way0 recent) evicts way1.
  assign w_vic    = ~io_dc.tag0_rd[TAG_W+1] ? 1'b0 : ~io_dc.tag1_rd[TAG_W+1] ? 1'b1 : r_lru[w_idx];
  assign w_vtag   = w_vic ? io_dc.tag1_rd : io_dc.tag0_rd;
  assign w_next   = w_idle  ? (io_dc.dc_req ? S_ACCESS : S_IDLE) :
                    w_acc   ? (w_hit ? S_IDLE : (w_vtag[TAG_W+1] & w_vtag[TAG_W]) ? S_WB : S_ALLOC) :
                    w_wb    ? (io_dc.l2_ack ? S_ALLOC : S_WB) :
                    w_alloc ? (io_dc.l2_ack ? S_REFILL : S_ALLOC) : S_IDLE;
  assign io_dc.index         = w_idx;
  assign io_dc.dc_offset     = io_dc.dc_addr[3:2];
  assign io_dc.dc_wd         = io_dc.dc_wr_data;
  assign io_dc.dc_data_wd    = r_line;
  assign io_dc.dc_done       = w_acc & w_hit;
  assign io_dc.dc_rd_data    = io_dc.dc_done ? w_line[{io_dc.dc_addr[3:2], 5'b0} +: 32] : 32'd0;
  assign io_dc.dc_stall      = io_dc.dc_req & ~io_dc.dc_done;
  assign io_dc.block0_re     = w_idle & io_dc.dc_req;
  assign io_dc.block1_re     = w_idle & io_dc.dc_req;
  assign io_dc.block0_we     = (w_st_hit & ~w_hit1) | (w_ref & ~r_victim);
  assign io_dc.block1_we     = (w_st_hit & w_hit1) | (w_ref & r_victim);
  assign io_dc.tag0_we       = io_dc.block0_we;
  assign io_dc.tag1_we       = io_dc.block1_we;
  assign io_dc.data_wd_dc_en = w_st_hit;
  assign io_dc.l2_wr_dc_en   = w_ref;
  assign io_dc.tag_wd        = w_st_hit ? {2'b11, w_tag} : w_ref ? {2'b10, w_tag} : '0;
  assign io_dc.l2_wb_req     = w_wb;
  assign io_dc.l2_rd_req     = w_alloc;
  assign io_dc.l2_addr       = w_wb ? {r_vic_tag, w_idx, 4'b0} : w_alloc ? {io_dc.dc_addr[31:4], 4'b0} : 32'd0;
  assign io_dc.l2_wb_data    = w_wb ? r_vic_line : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lru    <= '0;
      r_victim <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc & w_hit) r_lru[w_idx] <= ~w_hit1;
      if (w_acc & ~w_hit) begin
        r_victim   <= w_vic;
        r_vic_tag  <= w_vtag[TAG_W-1:0];
        r_vic_line <= w_vic ? io_dc.data1_rd : io_dc.data0_rd;
      end
      if (w_alloc & io_dc.l2_ack) r_line <= io_dc.l2_rd_data;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench with behavioural data/tag RAMs and an L2 responder of settable latency.
module tb_dcache_ctrl;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   lat = 1;
  logic l2_en = 1'b1;
  int   rd_cnt = 0;
  int   wb_cnt = 0;
  logic [31:0]  wb_addr = '0;
  logic [127:0] wb_data = '0;
  logic [127:0] d0 [256];
  logic [127:0] d1 [256];
  logic [21:0]  t0 [256] = '{default: '0};
  logic [21:0]  t1 [256] = '{default: '0};
  dcache_if bus ();
  dcache_ctrl dut (.clk(clk), .rst(rst), .io_dc(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [127:0] l2_line(input logic [31:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk) begin
    if (bus.block0_re) begin
      bus.data0_rd <= d0[bus.index];
      bus.tag0_rd  <= t0[bus.index];
    end
    if (bus.block1_re) begin
      bus.data1_rd <= d1[bus.index];
      bus.tag1_rd  <= t1[bus.index];
    end
    if (bus.block0_we) begin
      if (bus.l2_wr_dc_en) d0[bus.index] <= bus.dc_data_wd;
      else d0[bus.index][32*bus.dc_offset +: 32] <= bus.dc_wd;
    end
    if (bus.block1_we) begin
      if (bus.l2_wr_dc_en) d1[bus.index] <= bus.dc_data_wd;
      else d1[bus.index][32*bus.dc_offset +: 32] <= bus.dc_wd;
    end
    if (bus.tag0_we) t0[bus.index] <= bus.tag_wd;
    if (bus.tag1_we) t1[bus.index] <= bus.tag_wd;
  end
  initial begin
    int cnt;
    cnt = 0;
    bus.l2_ack = 1'b0;
    bus.l2_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.l2_ack = 1'b0;
      if (rst) cnt = 0;
      else if (l2_en && (bus.l2_rd_req || bus.l2_wb_req)) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          bus.l2_ack = 1'b1;
          if (bus.l2_rd_req) begin
            bus.l2_rd_data = l2_line(bus.l2_addr);
            rd_cnt++;
          end else begin
            wb_cnt++;
            wb_addr = bus.l2_addr;
            wb_data = bus.l2_wb_data;
          end
        end
      end
    end
  end
  task automatic xact(input string tag, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input int exp_n);
    int n;
    bus.dc_req = 1'b1;
    bus.dc_rw = rw;
    bus.dc_addr = a;
    bus.dc_wr_data = wd;
    n = 0;
    while (n < 200) begin
      step;
      n++;
      if (bus.dc_done) break;
    end
    chk({tag, "_done"}, bus.dc_done, 1'b1);
    chk({tag, "_lat"}, n, exp_n);
    if (!rw) chk({tag, "_data"}, bus.dc_rd_data, exp_d);
    step;
    bus.dc_req = 1'b0;
  endtask
  initial begin
    int w0;
    int n;
    rst = 1'b1;
    bus.dc_req = 1'b0;
    bus.dc_rw = 1'b0;
    bus.dc_addr = '0;
    bus.dc_wr_data = '0;
    repeat (3) step;
    bus.dc_req = 1'b1;
    #1;
    chk("rst_out", {bus.block0_re, bus.block1_re, bus.dc_done, bus.l2_rd_req, bus.l2_wb_req,
                    bus.block0_we, bus.block1_we, bus.tag0_we, bus.tag1_we}, 9'd0);
    bus.dc_req = 1'b0;
    step;
    rst = 1'b0;
    step;
    // cold load miss with cycle-level checks
    bus.dc_req = 1'b1;
    bus.dc_addr = 32'h0000_1234;
    #1;
    chk("t1_idle", {bus.block0_re, bus.block1_re, bus.dc_done, bus.dc_stall}, 4'b1101);
    chk("t1_idx", {bus.index, bus.dc_offset}, {8'h23, 2'd1});
    step;
    chk("t1_acc", {bus.dc_done, bus.l2_rd_req, bus.l2_wb_req, bus.dc_stall}, 4'b0001);
    step;
    chk("t1_alloc", {bus.l2_rd_req, bus.l2_wb_req, bus.dc_stall}, 3'b101);
    chk("t1_l2addr", bus.l2_addr, 32'h0000_1230);
    step;
    chk("t1_refill", {bus.l2_wr_dc_en, bus.block0_we, bus.block1_we, bus.tag0_we, bus.tag1_we,
                      bus.data_wd_dc_en, bus.l2_rd_req}, 7'b1101000);
    chk("t1_tagwd", bus.tag_wd, 22'h20_0001);
    chk("t1_line", bus.dc_data_wd, l2_line(32'h0000_1230));
    step;
    chk("t1_reissue", {bus.block0_re, bus.block1_re, bus.dc_done}, 3'b110);
    step;
    chk("t1_done", {bus.dc_done, bus.dc_rd_data}, {1'b1, 32'h0000_1234});
    chk("t1_rdcnt", rd_cnt, 1);
    step;
    bus.dc_req = 1'b0;
    // store hit
    bus.dc_req = 1'b1;
    bus.dc_rw = 1'b1;
    bus.dc_addr = 32'h0000_1238;
    bus.dc_wr_data = 32'hDEAD_BEEF;
    step;
    chk("t2_st", {bus.dc_done, bus.block0_we, bus.block1_we, bus.data_wd_dc_en, bus.tag0_we, bus.tag1_we,
                  bus.l2_wr_dc_en, bus.l2_rd_req, bus.l2_wb_req}, 9'b110110000);
    chk("t2_off", {bus.dc_offset, bus.dc_wd}, {2'd2, 32'hDEAD_BEEF});
    chk("t2_tagwd", bus.tag_wd, 22'h30_0001);
    step;
    bus.dc_req = 1'b0;
    xact("t2_ld", 1'b0, 32'h0000_1238, 32'd0, 32'hDEAD_BEEF, 1);
    chk("t2_rdcnt", rd_cnt, 1);
    // dirty eviction in set 0x23
    xact("t3_fill1", 1'b0, 32'h0000_2234, 32'd0, 32'h0000_2234, 5);
    xact("t3_touch1", 1'b0, 32'h0000_2238, 32'd0, 32'h0000_2238, 1);
    w0 = wb_cnt;
    xact("t3_evict", 1'b0, 32'h0000_3230, 32'd0, 32'h0000_3230, 6);
    chk("t3_wbcnt", wb_cnt, w0 + 1);
    chk("t3_wbaddr", wb_addr, 32'h0000_1230);
    chk("t3_wbdata", wb_data, {32'h0000_123C, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_1230});
    chk("t3_tags", {t0[8'h23], t1[8'h23]}, {22'h20_0003, 22'h20_0002});
    // LRU victim choice in set 0x45, clean lines only
    w0 = wb_cnt;
    xact("t4_a", 1'b0, 32'h0001_0450, 32'd0, 32'h0001_0450, 5);
    xact("t4_b", 1'b0, 32'h0002_0450, 32'd0, 32'h0002_0450, 5);
    xact("t4_a2", 1'b0, 32'h0001_0454, 32'd0, 32'h0001_0454, 1);
    xact("t4_b2", 1'b0, 32'h0002_0458, 32'd0, 32'h0002_0458, 1);
    xact("t4_a3", 1'b0, 32'h0001_045C, 32'd0, 32'h0001_045C, 1);
    xact("t4_c", 1'b0, 32'h0003_0450, 32'd0, 32'h0003_0450, 5);
    chk("t4_tags_c", {t0[8'h45], t1[8'h45]}, {22'h20_0010, 22'h20_0030});
    xact("t4_a4", 1'b0, 32'h0001_0450, 32'd0, 32'h0001_0450, 1);
    xact("t4_b3", 1'b0, 32'h0002_0454, 32'd0, 32'h0002_0454, 5);
    chk("t4_tags_b", {t0[8'h45], t1[8'h45]}, {22'h20_0010, 22'h20_0020});
    chk("t4_nowb", wb_cnt, w0);
    // writeback held for 20 cycles without ack in set 0x67
    xact("t6_st", 1'b1, 32'h0005_0670, 32'h0000_0055, 32'd0, 5);
    xact("t6_fill", 1'b0, 32'h0006_0670, 32'd0, 32'h0006_0670, 5);
    w0 = wb_cnt;
    lat = 21;
    bus.dc_req = 1'b1;
    bus.dc_rw = 1'b0;
    bus.dc_addr = 32'h0007_0670;
    step;
    step;
    for (int j = 1; j <= 20; j++) begin
      chk("t6_ctl", {bus.l2_wb_req, bus.l2_rd_req, bus.dc_stall, bus.l2_ack}, 4'b1010);
      chk("t6_addr", bus.l2_addr, 32'h0005_0670);
      chk("t6_data", bus.l2_wb_data, {32'h0005_067C, 32'h0005_0678, 32'h0005_0674, 32'h0000_0055});
      step;
    end
    n = 0;
    while (!bus.dc_done && n < 100) begin
      step;
      n++;
    end
    chk("t6_done", {bus.dc_done, bus.dc_rd_data}, {1'b1, 32'h0007_0670});
    chk("t6_wbcnt", wb_cnt, w0 + 1);
    chk("t6_tag0", t0[8'h67], 22'h20_0070);
    step;
    bus.dc_req = 1'b0;
    lat = 1;
    // reset while ALLOCATE is waiting on L2
    l2_en = 1'b0;
    bus.dc_req = 1'b1;
    bus.dc_addr = 32'h0009_0890;
    step;
    step;
    chk("t5_alloc", {bus.l2_rd_req, bus.l2_addr}, {1'b1, 32'h0009_0890});
    rst = 1'b1;
    bus.dc_req = 1'b0;
    #1;
    chk("t5_inrst", {bus.l2_rd_req, bus.l2_wb_req, bus.l2_wr_dc_en, bus.block0_we, bus.block1_we}, 5'd0);
    step;
    rst = 1'b0;
    #1;
    chk("t5_after", {bus.l2_rd_req, bus.l2_wb_req, bus.l2_wr_dc_en, bus.data_wd_dc_en, bus.block0_re,
                     bus.block1_re, bus.block0_we, bus.block1_we, bus.tag0_we, bus.tag1_we, bus.dc_done}, 11'd0);
    l2_en = 1'b1;
    bus.dc_req = 1'b1;
    #1;
    chk("t5_idle", {bus.block0_re, bus.block1_re}, 2'b11);
    bus.dc_req = 1'b0;
    step;
    // set 0x23 had way0 most recent; a cleared LRU now evicts way0
    xact("t5_lru", 1'b0, 32'h0000_4230, 32'd0, 32'h0000_4230, 5);
    chk("t5_tags", {t0[8'h23], t1[8'h23]}, {22'h20_0004, 22'h20_0002});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
